// File: rtl/phase_timer_sequencer_pkg.sv
// Shared types and constants for the phase timer sequencer and its countdown-timer link.
package ee371_timer_pkg;

    localparam int SEC_W   = 10;
    localparam int PHASE_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_RUN,
        ST_PAUSED,
        ST_ADVANCE,
        ST_ABORT
    } seq_state_t;

    // Maps a phase index to its configured duration in seconds.
    function automatic int dur_sel(input logic [PHASE_W-1:0] ph,
                                   input int p0, input int p1, input int p2, input int p3);
        if (ph == 2'd0)      return p0;
        else if (ph == 2'd1) return p1;
        else if (ph == 2'd2) return p2;
        else                 return p3;
    endfunction

endpackage

// File: rtl/phase_timer_sequencer_if.sv
// Link between the sequencer (master) and the 1 Hz countdown timer (slave).
interface phase_timer_sequencer_if #(
    parameter int SEC_W = 10
) ();
    logic             tmr_load;
    logic [SEC_W-1:0] tmr_seconds;
    logic             tmr_start;
    logic             tmr_done;

    modport master (output tmr_load, output tmr_seconds, output tmr_start, input tmr_done);
    modport slave  (input tmr_load, input tmr_seconds, input tmr_start, output tmr_done);
endinterface

// File: rtl/phase_timer_sequencer_rise_detect.sv
// Rising-edge detector: one history register and an AND gate.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);
    logic d_reg;

    always_ff @(posedge clk) begin
        if (reset) d_reg <= 1'b0;
        else       d_reg <= d;
    end

    assign rise = d & ~d_reg;
endmodule

// File: rtl/phase_timer_sequencer.sv
// Steps a countdown timer through a fixed list of timed phases with pause/resume and abort.
module phase_timer_sequencer #(
    parameter int SEC_W      = 10,
    parameter int NUM_PHASES = 3,
    parameter int PH0_SEC    = 300,
    parameter int PH1_SEC    = 420,
    parameter int PH2_SEC    = 480,
    parameter int PH3_SEC    = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            go,
    input  logic                            pause,
    input  logic                            abort,
    phase_timer_sequencer_if.master         tmr,
    output logic [1:0]                      phase,
    output logic                            busy,
    output logic                            paused,
    output logic                            phase_done,
    output logic                            seq_done
);
    import ee371_timer_pkg::*;

    seq_state_t         state_reg, state_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic               toggle_reg, toggle_next;
    logic               pause_rise;
    logic [SEC_W-1:0]   dur_tbl [4];
    logic [SEC_W-1:0]   cur_dur;
    logic               last_phase;
    logic               live;

    rise_detect u_pause_rise (
        .clk   (clk),
        .reset (reset),
        .d     (pause),
        .rise  (pause_rise)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_dur
        assign dur_tbl[gi] = SEC_W'(dur_sel(PHASE_W'(gi), PH0_SEC, PH1_SEC, PH2_SEC, PH3_SEC));
    end

    assign cur_dur    = dur_tbl[phase_reg];
    assign last_phase = (phase_reg == PHASE_W'(NUM_PHASES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            phase_reg  <= '0;
            toggle_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            toggle_reg <= toggle_next;
        end
    end

    // toggle_reg marks the first cycle after a pause or resume, when the
    // timer's run flag must be flipped to follow the state change.
    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        toggle_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (go) begin
                    state_next = ST_LOAD;
                    phase_next = '0;
                end
            end
            ST_LOAD: begin
                if (abort)             state_next = ST_ABORT;
                else if (cur_dur == 0) state_next = ST_ADVANCE;
                else                   state_next = ST_ARM;
            end
            ST_ARM: begin
                state_next = abort ? ST_ABORT : ST_RUN;
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_ABORT;
                end else if (tmr.tmr_done) begin
                    state_next = ST_ADVANCE;
                end else if (pause_rise) begin
                    state_next  = ST_PAUSED;
                    toggle_next = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (abort) begin
                    state_next = ST_ABORT;
                end else if (pause_rise) begin
                    state_next  = ST_RUN;
                    toggle_next = 1'b1;
                end
            end
            ST_ADVANCE: begin
                if (abort) begin
                    state_next = ST_ABORT;
                end else if (last_phase) begin
                    state_next = ST_IDLE;
                    phase_next = '0;
                end else begin
                    state_next = ST_LOAD;
                    phase_next = phase_reg + 1'b1;
                end
            end
            ST_ABORT: begin
                state_next = ST_IDLE;
                phase_next = '0;
            end
            default: begin
                state_next = ST_IDLE;
                phase_next = '0;
            end
        endcase
    end

    // Every output except tmr_load is held low while reset is asserted.
    assign live = ~reset;

    assign tmr.tmr_load    = reset | (state_reg == ST_LOAD) | (state_reg == ST_ABORT);
    assign tmr.tmr_seconds = (live && state_reg == ST_LOAD) ? cur_dur : '0;
    assign tmr.tmr_start   = live & ((state_reg == ST_ARM) |
                             (toggle_reg & ((state_reg == ST_RUN) | (state_reg == ST_PAUSED))));

    assign phase      = live ? phase_reg : 2'd0;
    assign busy       = live & (state_reg != ST_IDLE);
    assign paused     = live & (state_reg == ST_PAUSED);
    assign phase_done = live & (state_reg == ST_ADVANCE);
    assign seq_done   = live & (state_reg == ST_ADVANCE) & last_phase;

endmodule

// File: tb/tb_phase_timer_sequencer.sv
// Directed bench: sequencer paired with a behavioural 1 Hz countdown timer.
module tb_phase_timer_sequencer;

    logic       clk = 1'b0;
    logic       reset, go, pause, abort;
    logic [1:0] phase;
    logic       busy, paused, phase_done, seq_done;
    int         total = 0;
    int         bad   = 0;

    phase_timer_sequencer_if #(.SEC_W(10)) tif ();

    phase_timer_sequencer #(
        .SEC_W(10), .NUM_PHASES(3), .PH0_SEC(3), .PH1_SEC(0), .PH2_SEC(2), .PH3_SEC(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .pause      (pause),
        .abort      (abort),
        .tmr        (tif),
        .phase      (phase),
        .busy       (busy),
        .paused     (paused),
        .phase_done (phase_done),
        .seq_done   (seq_done)
    );

    always #5 clk = ~clk;

    // Countdown timer: tmr_load acts as its reset, tmr_start toggles the run flag.
    logic [9:0] cnt;
    logic       run;
    always_ff @(posedge clk) begin
        if (tif.tmr_load) begin
            cnt <= tif.tmr_seconds;
            run <= 1'b0;
        end else begin
            if (tif.tmr_start) run <= ~run;
            if (run && cnt != 0) cnt <= cnt - 1'b1;
        end
    end
    assign tif.tmr_done = (cnt == 10'd0);

    typedef struct {
        logic       go, pause, abort;
        logic       load, start;
        logic [9:0] sec;
        logic [1:0] ph;
        logic       busy, paused, pd, sd, done;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic g, input logic p, input logic a, input logic r);
        @(negedge clk);
        go = g; pause = p; abort = a; reset = r;
        #1;
    endtask

    task automatic chk_out(input string tag, input vec_t v);
        chk({tag, ".load"},   32'(tif.tmr_load),    32'(v.load));
        chk({tag, ".start"},  32'(tif.tmr_start),   32'(v.start));
        chk({tag, ".sec"},    32'(tif.tmr_seconds), 32'(v.sec));
        chk({tag, ".phase"},  32'(phase),           32'(v.ph));
        chk({tag, ".busy"},   32'(busy),            32'(v.busy));
        chk({tag, ".paused"}, 32'(paused),          32'(v.paused));
        chk({tag, ".pdone"},  32'(phase_done),      32'(v.pd));
        chk({tag, ".sdone"},  32'(seq_done),        32'(v.sd));
        chk({tag, ".tdone"},  32'(tif.tmr_done),    32'(v.done));
    endtask

    // Plain sequence from a go pulse; expects the timer count at 0 on entry.
    task automatic run_table(input string tag);
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].go, tbl[i].pause, tbl[i].abort, 1'b0);
            $display("%s c%0d: load=%0b start=%0b sec=%0d ph=%0d busy=%0b pd=%0b sd=%0b",
                     tag, i, tif.tmr_load, tif.tmr_start, tif.tmr_seconds, phase, busy,
                     phase_done, seq_done);
            chk_out($sformatf("%s.c%0d", tag, i), tbl[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_start, pd_early, sd_seen, pd_cyc;
        vec_t rst_v, idle_v;

        //            go pau abt load st sec ph busy pau pd sd done
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_v  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        idle_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; go = 1'b0; pause = 1'b0; abort = 1'b0;

        // Reset state
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk_out("rst", rst_v);
        cyc(0, 0, 0, 0);
        chk_out("idle", idle_v);

        // 1: full sequence 3/0/2
        run_table("seq1");

        // 2: pause in second RUN cycle of phase 0, resume four cycles later.
        // The timer's run flag still counts on the pause-entry edge, so count
        // reaches 0 while PAUSED; the sequencer must ignore it until resumed.
        n_start = 0; pd_early = 0; pd_cyc = -1;
        for (int c = 0; c <= 10; c++) begin
            cyc(c == 0, (c == 4) || (c == 5) || (c == 8), 1'b0, 1'b0);
            $display("pause c%0d: paused=%0b start=%0b tdone=%0b pd=%0b",
                     c, paused, tif.tmr_start, tif.tmr_done, phase_done);
            if (tif.tmr_start) n_start++;
            if (phase_done && pd_cyc < 0) pd_cyc = c;
            if (phase_done && c < 10) pd_early++;
            if (c >= 5 && c <= 8) chk($sformatf("p2.paused.c%0d", c), 32'(paused), 32'd1);
            if (c == 5 || c == 9) chk($sformatf("p2.start.c%0d", c), 32'(tif.tmr_start), 32'd1);
            if (c == 7) chk("p2.tdone_in_pause", 32'(tif.tmr_done), 32'd1);
            if (c == 9) chk("p2.resumed", 32'(paused), 32'd0);
        end
        chk("p2.start_count", 32'(n_start), 32'd3);
        chk("p2.pd_early", 32'(pd_early), 32'd0);
        chk("p2.pd_cycle", 32'(pd_cyc), 32'd10);
        cyc(0, 0, 1, 0);                    // LOAD of phase 1, abort
        chk("p2.load_ph1", 32'(phase), 32'd1);
        cyc(0, 0, 0, 0);
        chk("p2.abort_load", 32'(tif.tmr_load), 32'd1);
        chk("p2.abort_sec", 32'(tif.tmr_seconds), 32'd0);
        cyc(0, 0, 0, 0);
        chk("p2.idle_busy", 32'(busy), 32'd0);

        // 3: abort in RUN of phase 2
        sd_seen = 0;
        for (int c = 0; c <= 14; c++) begin
            cyc(c == 0, 1'b0, c == 12, 1'b0);
            if (seq_done) sd_seen++;
            if (c == 12) chk("p3.run_ph2", 32'(phase), 32'd2);
            if (c == 13) begin
                $display("abort c13: load=%0b sec=%0d busy=%0b", tif.tmr_load, tif.tmr_seconds, busy);
                chk("p3.abort_load", 32'(tif.tmr_load), 32'd1);
                chk("p3.abort_sec", 32'(tif.tmr_seconds), 32'd0);
                chk("p3.abort_busy", 32'(busy), 32'd1);
                chk("p3.abort_pd", 32'(phase_done), 32'd0);
            end
        end
        chk("p3.idle_busy", 32'(busy), 32'd0);
        chk("p3.idle_phase", 32'(phase), 32'd0);
        chk("p3.timer_stopped", 32'(tif.tmr_done), 32'd1);
        chk("p3.no_seq_done", 32'(sd_seen), 32'd0);

        // 4: pause edge in the same cycle as tmr_done
        for (int c = 0; c <= 6; c++) cyc(c == 0, c == 6, 1'b0, 1'b0);
        chk("p4.tdone", 32'(tif.tmr_done), 32'd1);
        cyc(0, 1, 0, 0);
        $display("coincide c7: pd=%0b paused=%0b start=%0b", phase_done, paused, tif.tmr_start);
        chk("p4.advance", 32'(phase_done), 32'd1);
        chk("p4.not_paused", 32'(paused), 32'd0);
        chk("p4.no_start", 32'(tif.tmr_start), 32'd0);
        cyc(0, 1, 1, 0);
        chk("p4.load_ph1_paused", 32'(paused), 32'd0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("p4.idle", 32'(busy), 32'd0);

        // 5: reset while PAUSED, then a normal sequence
        for (int c = 0; c <= 5; c++) cyc(c == 0, c >= 4, 1'b0, 1'b0);
        chk("p5.paused", 32'(paused), 32'd1);
        cyc(0, 0, 0, 1);
        $display("reset c6: load=%0b busy=%0b paused=%0b", tif.tmr_load, busy, paused);
        chk_out("p5.rst_a", '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                               tif.tmr_done});
        cyc(0, 0, 0, 1);
        chk_out("p5.rst_b", rst_v);
        cyc(0, 0, 0, 0);
        chk_out("p5.idle", idle_v);
        run_table("seq5");

        // 6: go held high across the end of a sequence
        for (int c = 0; c <= 17; c++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (c == 15) chk("p6.seq_done", 32'(seq_done), 32'd1);
            if (c == 16) chk("p6.idle", 32'(busy), 32'd0);
            if (c == 17) begin
                $display("b2b c17: busy=%0b load=%0b ph=%0d sec=%0d", busy, tif.tmr_load, phase,
                         tif.tmr_seconds);
                chk("p6.reload_busy", 32'(busy), 32'd1);
                chk("p6.reload_load", 32'(tif.tmr_load), 32'd1);
                chk("p6.reload_phase", 32'(phase), 32'd0);
                chk("p6.reload_sec", 32'(tif.tmr_seconds), 32'd3);
            end
        end
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("p6.final_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
